// File: rtl/cavlc_bitstream_packer.sv
// cavlc_bitstream_packer
//   Packs right-justified variable-length codes MSB-first into OUT_W-bit words.
//   A flush request closes the slice: optional RBSP stop bit, zero pad to a
//   byte boundary, then the partial word is emitted with out_last and its byte
//   count, followed by a one-cycle flush_done pulse.
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    code handshake; in_code[in_bits-1:0] holds the code
//   flush                slice-end request (only honoured in RUN)
//   out_valid/out_ready  word handshake; out_word first bit at MSB
//   out_bytes, out_last  valid bytes in out_word, final word of a flush
//   flush_done           one-cycle pulse after the final word is taken
//   bit_count            code bits accepted since the last flush_done
module cavlc_bitstream_packer #(
  parameter int unsigned CODE_W     = 128,
  parameter int unsigned BIT_W      = 7,
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned ALIGN_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CODE_W-1:0]          in_code,
  input  logic [BIT_W-1:0]           in_bits,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_word,
  output logic [$clog2(OUT_W/8):0]   out_bytes,
  output logic                       out_last,
  output logic                       flush_done,
  output logic [31:0]                bit_count
);

  localparam int unsigned ACC_W   = CODE_W + OUT_W;
  // Headroom above ACC_W so the pad round-up cannot wrap.
  localparam int unsigned FILL_W  = $clog2(ACC_W + 8);
  localparam int unsigned BYTES_W = $clog2(OUT_W/8) + 1;

  localparam logic [FILL_W-1:0]  OUT_W_F    = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0]  TWO_OUT_F  = FILL_W'(2*OUT_W);
  localparam logic [FILL_W-1:0]  ACC_W_F    = FILL_W'(ACC_W);
  localparam logic [FILL_W-1:0]  SEVEN_F    = FILL_W'(7);
  localparam logic [BYTES_W-1:0] FULL_BYTES = BYTES_W'(OUT_W/8);

  typedef enum logic [1:0] {RUN, PAD, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [31:0]         count_q, count_d;
  logic                done_q, done_d;

  logic                final_word;
  logic                in_fire, out_fire;
  logic [ACC_W-1:0]    acc_sh;
  logic [FILL_W-1:0]   fill_sh;
  logic [FILL_W-1:0]   fill_pad;
  logic [FILL_W-1:0]   shift_amt;
  logic [CODE_W-1:0]   code_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Output side
  always_comb begin
    final_word = (state_q == DRAIN) && (fill_q != '0) && (fill_q <= OUT_W_F);
    out_valid  = 1'b0;
    case (state_q)
      RUN, PAD: out_valid = (fill_q >= OUT_W_F);
      DRAIN:    out_valid = (fill_q != '0);
      default:  out_valid = 1'b0;
    endcase
    out_word  = acc_q[ACC_W-1 -: OUT_W];
    out_last  = final_word;
    out_bytes = '0;
    if (final_word)     out_bytes = BYTES_W'(fill_q >> 3);
    else if (out_valid) out_bytes = FULL_BYTES;
    in_ready = !rst && (state_q == RUN) && !flush &&
               ((fill_q < OUT_W_F) || ((fill_q < TWO_OUT_F) && out_ready));
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
  end

  // Next state: a full-word pop is applied first, then append/pad lands
  // below the remaining bits.
  always_comb begin
    acc_sh  = acc_q;
    fill_sh = fill_q;
    if (out_fire && !final_word) begin
      acc_sh  = acc_q << OUT_W;
      fill_sh = fill_q - OUT_W_F;
    end
    state_d = state_q;
    acc_d   = acc_sh;
    fill_d  = fill_sh;
    count_d = count_q;
    done_d  = 1'b0;

    code_mask = in_code & ~({CODE_W{1'b1}} << in_bits);
    shift_amt = ACC_W_F - fill_sh - FILL_W'(in_bits);
    fill_pad  = fill_sh;
    if (ALIGN_MODE != 0) fill_pad = fill_sh + FILL_W'(1);

    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = PAD;
        end else if (in_fire) begin
          acc_d   = acc_sh | (ACC_W'(code_mask) << shift_amt);
          fill_d  = fill_sh + FILL_W'(in_bits);
          count_d = count_q + 32'(in_bits);
        end
      end
      PAD: begin
        if (ALIGN_MODE != 0) acc_d = acc_sh | ({1'b1, {(ACC_W-1){1'b0}}} >> fill_sh);
        fill_d  = (fill_pad + SEVEN_F) & ~SEVEN_F;
        state_d = DRAIN;
      end
      DRAIN: begin
        if ((fill_q == '0) || (final_word && out_ready)) begin
          acc_d   = '0;
          fill_d  = '0;
          count_d = '0;
          done_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign flush_done = done_q;
  assign bit_count  = count_q;

endmodule

// File: tb/tb_cavlc_bitstream_packer.sv
module tb_cavlc_bitstream_packer;
  localparam int CODE_W = 128;
  localparam int BIT_W  = 7;
  localparam int OUT_W  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ALIGN_MODE=1 instance
  logic              in_valid, in_ready, flush, out_valid, out_ready, out_last, flush_done;
  logic [CODE_W-1:0] in_code;
  logic [BIT_W-1:0]  in_bits;
  logic [OUT_W-1:0]  out_word;
  logic [2:0]        out_bytes;
  logic [31:0]       bit_count;

  // ALIGN_MODE=0 instance
  logic              a0_in_valid, a0_in_ready, a0_flush, a0_out_valid, a0_out_ready, a0_out_last, a0_flush_done;
  logic [CODE_W-1:0] a0_in_code;
  logic [BIT_W-1:0]  a0_in_bits;
  logic [OUT_W-1:0]  a0_out_word;
  logic [2:0]        a0_out_bytes;
  logic [31:0]       a0_bit_count;

  cavlc_bitstream_packer #(.CODE_W(CODE_W), .BIT_W(BIT_W), .OUT_W(OUT_W), .ALIGN_MODE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_bits(in_bits), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_bytes(out_bytes), .out_last(out_last),
    .flush_done(flush_done), .bit_count(bit_count));

  cavlc_bitstream_packer #(.CODE_W(CODE_W), .BIT_W(BIT_W), .OUT_W(OUT_W), .ALIGN_MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(a0_in_valid), .in_ready(a0_in_ready), .in_code(a0_in_code),
    .in_bits(a0_in_bits), .flush(a0_flush), .out_valid(a0_out_valid), .out_ready(a0_out_ready),
    .out_word(a0_out_word), .out_bytes(a0_out_bytes), .out_last(a0_out_last),
    .flush_done(a0_flush_done), .bit_count(a0_bit_count));

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  b;
    logic        l;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   mbits[$];

  task automatic chk(input logic [127:0] obs, input logic [127:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference bit-stream model: codes appended MSB-first, full words queued.
  task automatic model_pop_word(input int nbits, input logic last);
    exp_t e;
    e.w = '0;
    for (int i = 0; i < nbits; i++) e.w[31-i] = mbits.pop_front();
    e.b = 3'(nbits / 8);
    e.l = last;
    exp_q.push_back(e);
  endtask

  task automatic model_add(input logic [127:0] c, input int b);
    for (int i = b - 1; i >= 0; i--) mbits.push_back(c[i]);
    while (mbits.size() >= 32) model_pop_word(32, 1'b0);
  endtask

  task automatic model_flush();
    mbits.push_back(1'b1);
    while (mbits.size() % 8 != 0) mbits.push_back(1'b0);
    if (mbits.size() > 0) model_pop_word(mbits.size(), 1'b1);
  endtask

  // Scoreboard: compare every word the DUT hands over.
  always @(negedge clk) begin
    if (!rst && flush_done) done_cnt++;
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_word observed=%0h expected=none", out_word);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk(out_word, mon_e.w, "sb_word");
        chk(out_bytes, mon_e.b, "sb_bytes");
        chk(out_last, mon_e.l, "sb_last");
      end
    end
  end

  task automatic send(input logic [127:0] c, input int b);
    int n = 0;
    in_valid = 1'b1; in_code = c; in_bits = 7'(b);
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk(in_ready, 1, "send_accept");
    model_add(c, b);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic flush1();
    int n = 0;
    model_flush();
    flush = 1'b1;
    #1 chk(in_ready, 0, "flush_blocks_input");
    @(posedge clk); #1;
    flush = 1'b0;
    while (!flush_done && n < 100) begin @(negedge clk); n++; end
    chk(flush_done, 1, "flush_done_seen");
    chk(bit_count, 0, "bit_count_cleared");
    @(negedge clk);
    chk(flush_done, 0, "flush_done_pulse");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    int n;
    bit saw;
    rst = 1'b1; in_valid = 1'b0; in_code = '0; in_bits = '0; flush = 1'b0; out_ready = 1'b1;
    a0_in_valid = 1'b0; a0_in_code = '0; a0_in_bits = '0; a0_flush = 1'b0; a0_out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk(out_valid, 0, "rst_out_valid");
    chk(out_word, 0, "rst_out_word");
    chk(out_bytes, 0, "rst_out_bytes");
    chk(out_last, 0, "rst_out_last");
    chk(in_ready, 0, "rst_in_ready");
    chk(bit_count, 0, "rst_bit_count");
    chk(flush_done, 0, "rst_flush_done");
    rst = 1'b0;
    @(posedge clk); #1;

    // 0b101 then flush -> 0xB0000000, one byte, last
    send(128'h5, 3);
    chk(bit_count, 3, "bc_after_101");
    flush1();

    // Two 16-bit codes make a full word, no flush activity
    saved = done_cnt;
    send(128'h1234, 16);
    send(128'h5678, 16);
    chk(bit_count, 32, "bc_after_32");
    @(posedge clk); @(posedge clk); #1;
    chk(done_cnt, saved, "no_flush_done");
    chk(out_valid, 0, "empty_after_word");

    // Flush with empty accumulator -> stop bit only
    flush1();

    // 127 ones under backpressure
    out_ready = 1'b0;
    send({CODE_W{1'b1}}, 127);
    chk(bit_count, 127, "bc_after_127");
    @(negedge clk);
    chk(in_ready, 0, "stall_in_ready");
    chk(out_valid, 1, "stall_out_valid");
    chk(out_word, 32'hFFFF_FFFF, "stall_word");
    repeat (3) @(negedge clk);
    chk(out_word, 32'hFFFF_FFFF, "stall_word_held");
    chk(out_bytes, 4, "stall_bytes_held");
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(out_valid, 0, "fill31_no_word");
    @(posedge clk); #1;
    flush1();

    // Simultaneous input and output fire at fill=40
    out_ready = 1'b0;
    send(128'h1234_5678_9ABC_DEF0_0000_00C3_5A96_F00F, 40);
    out_ready = 1'b1;
    in_valid = 1'b1; in_code = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA_BCDE; in_bits = 7'd20;
    @(negedge clk);
    chk(in_ready, 1, "both_in_ready");
    chk(out_valid, 1, "both_out_valid");
    model_add(in_code, 20);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk(out_valid, 0, "fill28_no_word");
    chk(in_ready, 1, "fill28_in_ready");
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(128'hDEAD_BEEF_0000_0000_0000_03C5_A5F0_0F96, 42);
    out_ready = 1'b1;
    @(negedge clk);
    chk(in_ready, 0, "fill70_in_ready");
    chk(out_valid, 1, "fill70_out_valid");
    repeat (3) @(posedge clk);
    #1;
    flush1();

    // Reset while the final word is stalled in DRAIN
    out_ready = 1'b0;
    send(128'hFFF, 12);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk(out_valid, 1, "drain_valid");
    chk(out_last, 1, "drain_last");
    chk(out_bytes, 2, "drain_bytes");
    chk(out_word, 32'hFFF8_0000, "drain_word");
    rst = 1'b1;
    #1;
    chk(out_valid, 0, "midrst_out_valid");
    chk(out_word, 0, "midrst_out_word");
    chk(out_bytes, 0, "midrst_out_bytes");
    chk(out_last, 0, "midrst_out_last");
    chk(in_ready, 0, "midrst_in_ready");
    chk(bit_count, 0, "midrst_bit_count");
    mbits.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(128'hA, 4);
    flush1();

    // ALIGN_MODE=0: empty flush emits nothing but still completes
    a0_flush = 1'b1;
    @(posedge clk); #1;
    a0_flush = 1'b0;
    n = 0; saw = 1'b0;
    while (!a0_flush_done && n < 8) begin
      @(negedge clk);
      if (a0_out_valid) saw = 1'b1;
      n++;
    end
    chk(a0_flush_done, 1, "a0_empty_done");
    chk(saw, 0, "a0_empty_no_word");
    @(posedge clk); #1;

    // ALIGN_MODE=0: 0xA/4 pads with zeros only
    a0_in_valid = 1'b1; a0_in_code = 128'hA; a0_in_bits = 7'd4;
    @(negedge clk);
    chk(a0_in_ready, 1, "a0_accept");
    @(posedge clk); #1;
    a0_in_valid = 1'b0;
    a0_flush = 1'b1;
    @(posedge clk); #1;
    a0_flush = 1'b0;
    n = 0;
    @(negedge clk);
    while (!a0_out_valid && n < 10) begin @(negedge clk); n++; end
    chk(a0_out_valid, 1, "a0_final_valid");
    chk(a0_out_word, 32'hA000_0000, "a0_final_word");
    chk(a0_out_bytes, 1, "a0_final_bytes");
    chk(a0_out_last, 1, "a0_final_last");
    @(negedge clk);
    chk(a0_flush_done, 1, "a0_final_done");

    repeat (4) @(posedge clk);
    chk(exp_q.size(), 0, "sb_drained");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
